// File: rtl/riscv_pkg.sv
// Shared RISC-V pipeline constants and types.
//   - write-back source select encodings (WB_*)
//   - load/store func3 encodings (F3_*)
//   - memory/write-back stage FSM states (STATE_*)
//   - access_size(): decodes func3 into a byte/half/word access size
package riscv_pkg;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic {
    STATE_IDLE = 1'b0,
    STATE_WAIT = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } size_t;

  // Stores only know SB/SH, everything else is a word. Loads also accept
  // the unsigned byte/half encodings.
  function automatic size_t access_size(input logic [2:0] f3, input logic is_store);
    size_t sz;
    sz = SZ_WORD;
    if (is_store) begin
      case (f3)
        F3_B:    sz = SZ_BYTE;
        F3_H:    sz = SZ_HALF;
        default: sz = SZ_WORD;
      endcase
    end else begin
      case (f3)
        F3_B, F3_BU: sz = SZ_BYTE;
        F3_H, F3_HU: sz = SZ_HALF;
        default:     sz = SZ_WORD;
      endcase
    end
    return sz;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Load/store lane alignment (purely combinational).
// Ports:
//   st_func3, st_addr_lo, st_is_store, st_data : access being issued
//   st_wdata, st_be                            : lane-replicated store data, byte enables
//   misalign                                   : access size does not fit its address
//   ld_func3, ld_addr_lo, ld_rdata             : captured load info and returned word
//   ld_data                                    : extracted, sign/zero-extended load value
module lsu_align
  import riscv_pkg::*;
(
  input  logic [2:0]  st_func3,
  input  logic [1:0]  st_addr_lo,
  input  logic        st_is_store,
  input  logic [31:0] st_data,
  output logic [31:0] st_wdata,
  output logic [3:0]  st_be,
  output logic        misalign,
  input  logic [2:0]  ld_func3,
  input  logic [1:0]  ld_addr_lo,
  input  logic [31:0] ld_rdata,
  output logic [31:0] ld_data
);

  size_t       st_size;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    st_size  = access_size(st_func3, st_is_store);
    misalign = ((st_size == SZ_HALF) && st_addr_lo[0]) ||
               ((st_size == SZ_WORD) && (st_addr_lo != 2'b00));
    // Data is replicated across all lanes so the byte enables alone pick
    // the target bytes in memory.
    case (st_size)
      SZ_BYTE: begin
        st_wdata = {4{st_data[7:0]}};
        st_be    = 4'b0001 << st_addr_lo;
      end
      SZ_HALF: begin
        st_wdata = {2{st_data[15:0]}};
        st_be    = 4'b0011 << {st_addr_lo[1], 1'b0};
      end
      default: begin
        st_wdata = st_data;
        st_be    = 4'b1111;
      end
    endcase
  end

  always_comb begin
    case (ld_addr_lo)
      2'd0:    ld_byte = ld_rdata[7:0];
      2'd1:    ld_byte = ld_rdata[15:8];
      2'd2:    ld_byte = ld_rdata[23:16];
      default: ld_byte = ld_rdata[31:24];
    endcase
    ld_half = ld_addr_lo[1] ? ld_rdata[31:16] : ld_rdata[15:0];
    case (ld_func3)
      F3_B:    ld_data = {{24{ld_byte[7]}}, ld_byte};
      F3_BU:   ld_data = {24'd0, ld_byte};
      F3_H:    ld_data = {{16{ld_half[15]}}, ld_half};
      F3_HU:   ld_data = {16'd0, ld_half};
      default: ld_data = ld_rdata;
    endcase
  end

endmodule

// File: rtl/mem_wb_stage.sv
// Memory-access and writeback stage.
// Takes the EX/MEM fields, runs loads/stores over a req/ack data-memory
// handshake (stalling upstream while outstanding) and produces the
// registered register-file write port.
// Ports:
//   clk, rst (async, active low)
//   i_alu_result, i_store_data, i_pc4, i_func3, i_mem_w_en,
//   i_w_idx, i_wb_sel, i_wb_en        : EX/MEM pipeline fields
//   o_stall                           : hold upstream stages (combinational)
//   o_dmem_req/we/addr/wdata/be       : registered memory request
//   i_dmem_ack, i_dmem_rdata          : memory completion and read data
//   o_misalign                        : one-cycle pulse for a misaligned access
//   o_wr_en, o_wr_idx, o_wr_data      : registered register-file write
module mem_wb_stage
  import riscv_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       i_alu_result,
  input  logic [31:0]       i_store_data,
  input  logic [31:0]       i_pc4,
  input  logic [2:0]        i_func3,
  input  logic              i_mem_w_en,
  input  logic [4:0]        i_w_idx,
  input  logic [1:0]        i_wb_sel,
  input  logic              i_wb_en,
  output logic              o_stall,
  output logic              o_dmem_req,
  output logic              o_dmem_we,
  output logic [ADDR_W-1:0] o_dmem_addr,
  output logic [31:0]       o_dmem_wdata,
  output logic [3:0]        o_dmem_be,
  input  logic              i_dmem_ack,
  input  logic [31:0]       i_dmem_rdata,
  output logic              o_misalign,
  output logic              o_wr_en,
  output logic [4:0]        o_wr_idx,
  output logic [31:0]       o_wr_data
);

  state_t      state_reg;
  logic [4:0]  w_idx_reg;
  logic [2:0]  func3_reg;
  logic [1:0]  addr_lo_reg;
  logic        ld_wen_reg;

  logic        is_load;
  logic        is_store;
  logic        mem_op;
  logic        misalign;
  logic [31:0] st_wdata;
  logic [3:0]  st_be;
  logic [31:0] ld_data;

  assign is_store = i_mem_w_en;
  assign is_load  = (i_wb_sel == WB_MEM) && !i_mem_w_en;
  assign mem_op   = is_load || is_store;

  lsu_align u_lsu_align (
    .st_func3    (i_func3),
    .st_addr_lo  (i_alu_result[1:0]),
    .st_is_store (is_store),
    .st_data     (i_store_data),
    .st_wdata    (st_wdata),
    .st_be       (st_be),
    .misalign    (misalign),
    .ld_func3    (func3_reg),
    .ld_addr_lo  (addr_lo_reg),
    .ld_rdata    (i_dmem_rdata),
    .ld_data     (ld_data)
  );

  // Misaligned accesses are dropped in the decision cycle, so they never stall.
  always_comb begin
    o_stall = 1'b0;
    case (state_reg)
      STATE_IDLE: o_stall = mem_op && !misalign;
      STATE_WAIT: o_stall = !i_dmem_ack;
      default:    o_stall = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= STATE_IDLE;
      w_idx_reg    <= 5'd0;
      func3_reg    <= 3'd0;
      addr_lo_reg  <= 2'd0;
      ld_wen_reg   <= 1'b0;
      o_dmem_req   <= 1'b0;
      o_dmem_we    <= 1'b0;
      o_dmem_addr  <= '0;
      o_dmem_wdata <= 32'd0;
      o_dmem_be    <= 4'd0;
      o_misalign   <= 1'b0;
      o_wr_en      <= 1'b0;
      o_wr_idx     <= 5'd0;
      o_wr_data    <= 32'd0;
    end else begin
      o_misalign <= 1'b0;
      case (state_reg)
        STATE_IDLE: begin
          if (mem_op) begin
            o_wr_en <= 1'b0;
            if (misalign) begin
              o_misalign <= 1'b1;
            end else begin
              state_reg    <= STATE_WAIT;
              o_dmem_req   <= 1'b1;
              o_dmem_we    <= is_store;
              o_dmem_addr  <= {i_alu_result[ADDR_W-1:2], 2'b00};
              o_dmem_wdata <= is_store ? st_wdata : 32'd0;
              o_dmem_be    <= is_store ? st_be : 4'b1111;
              w_idx_reg    <= i_w_idx;
              func3_reg    <= i_func3;
              addr_lo_reg  <= i_alu_result[1:0];
              ld_wen_reg   <= is_load && i_wb_en;
            end
          end else begin
            o_wr_en   <= i_wb_en && (i_w_idx != 5'd0);
            o_wr_idx  <= i_w_idx;
            o_wr_data <= (i_wb_sel == WB_PC4) ? i_pc4 : i_alu_result;
          end
        end
        STATE_WAIT: begin
          // Request registers stay untouched until the ack so the memory
          // sees a stable request for the whole access.
          if (i_dmem_ack) begin
            state_reg  <= STATE_IDLE;
            o_dmem_req <= 1'b0;
            o_wr_en    <= ld_wen_reg && (w_idx_reg != 5'd0);
            if (ld_wen_reg) begin
              o_wr_idx  <= w_idx_reg;
              o_wr_data <= ld_data;
            end
          end else begin
            o_wr_en <= 1'b0;
          end
        end
        default: state_reg <= STATE_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] i_alu_result, i_store_data, i_pc4;
  logic [2:0]  i_func3;
  logic        i_mem_w_en;
  logic [4:0]  i_w_idx;
  logic [1:0]  i_wb_sel;
  logic        i_wb_en;
  logic        o_stall, o_dmem_req, o_dmem_we;
  logic [31:0] o_dmem_addr, o_dmem_wdata;
  logic [3:0]  o_dmem_be;
  logic        i_dmem_ack;
  logic [31:0] i_dmem_rdata;
  logic        o_misalign, o_wr_en;
  logic [4:0]  o_wr_idx;
  logic [31:0] o_wr_data;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_wb_stage #(.ADDR_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_alu_result (i_alu_result),
    .i_store_data (i_store_data),
    .i_pc4        (i_pc4),
    .i_func3      (i_func3),
    .i_mem_w_en   (i_mem_w_en),
    .i_w_idx      (i_w_idx),
    .i_wb_sel     (i_wb_sel),
    .i_wb_en      (i_wb_en),
    .o_stall      (o_stall),
    .o_dmem_req   (o_dmem_req),
    .o_dmem_we    (o_dmem_we),
    .o_dmem_addr  (o_dmem_addr),
    .o_dmem_wdata (o_dmem_wdata),
    .o_dmem_be    (o_dmem_be),
    .i_dmem_ack   (i_dmem_ack),
    .i_dmem_rdata (i_dmem_rdata),
    .o_misalign   (o_misalign),
    .o_wr_en      (o_wr_en),
    .o_wr_idx     (o_wr_idx),
    .o_wr_data    (o_wr_data)
  );

  typedef struct {
    string       name;
    logic [31:0] alu;
    logic [31:0] pc4;
    logic [2:0]  f3;
    logic        mw;
    logic [4:0]  idx;
    logic [1:0]  sel;
    logic        en;
    logic        x_wr_en;
    logic [31:0] x_wr_data;
    logic        x_mis;
  } vec_t;

  vec_t vecs[10];

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] alu, input logic [31:0] sd, input logic [31:0] pc4,
                       input logic [2:0] f3, input logic mw, input logic [4:0] idx,
                       input logic [1:0] sel, input logic en);
    i_alu_result = alu;
    i_store_data = sd;
    i_pc4        = pc4;
    i_func3      = f3;
    i_mem_w_en   = mw;
    i_w_idx      = idx;
    i_wb_sel     = sel;
    i_wb_en      = en;
  endtask

  task automatic bubble();
    drive(32'd0, 32'd0, 32'd0, 3'd0, 1'b0, 5'd0, 2'b00, 1'b0);
  endtask

  task automatic chk_all_zero(input string nm);
    chk1 ({nm, "_req"},   o_dmem_req, 1'b0);
    chk1 ({nm, "_we"},    o_dmem_we, 1'b0);
    chk32({nm, "_addr"},  o_dmem_addr, 32'd0);
    chk32({nm, "_wdata"}, o_dmem_wdata, 32'd0);
    chk32({nm, "_be"},    {28'd0, o_dmem_be}, 32'd0);
    chk1 ({nm, "_mis"},   o_misalign, 1'b0);
    chk1 ({nm, "_wren"},  o_wr_en, 1'b0);
    chk32({nm, "_wridx"}, {27'd0, o_wr_idx}, 32'd0);
    chk32({nm, "_wrdat"}, o_wr_data, 32'd0);
  endtask

  // One aligned memory access: decision cycle, `waits` un-acked WAIT cycles,
  // then the ack cycle. Called right after a rising edge (+1).
  task automatic do_mem(input string nm, input logic [31:0] alu, input logic [31:0] sd,
                        input logic [2:0] f3, input logic mw, input logic [4:0] idx,
                        input logic [1:0] sel, input logic en, input int waits,
                        input logic [31:0] rdata, input logic [31:0] x_addr,
                        input logic x_we, input logic [3:0] x_be, input logic [31:0] x_wdata,
                        input logic x_wr_en, input logic [31:0] x_wr_data);
    int stalls;
    stalls = 0;
    drive(alu, sd, alu + 32'd4, f3, mw, idx, sel, en);
    #1;
    if (o_stall) stalls++;
    chk1({nm, "_stall_decide"}, o_stall, 1'b1);
    tick();
    chk1 ({nm, "_req"},   o_dmem_req, 1'b1);
    chk1 ({nm, "_we"},    o_dmem_we, x_we);
    chk32({nm, "_addr"},  o_dmem_addr, x_addr);
    chk32({nm, "_be"},    {28'd0, o_dmem_be}, {28'd0, x_be});
    chk32({nm, "_wdata"}, o_dmem_wdata, x_wdata);
    chk1 ({nm, "_wren_req"}, o_wr_en, 1'b0);
    for (int i = 0; i < waits; i++) begin
      if (o_stall) stalls++;
      chk1({nm, "_stall_wait"}, o_stall, 1'b1);
      tick();
      chk1 ({nm, "_req_held"},  o_dmem_req, 1'b1);
      chk32({nm, "_addr_held"}, o_dmem_addr, x_addr);
      chk1 ({nm, "_wren_wait"}, o_wr_en, 1'b0);
    end
    i_dmem_ack   = 1'b1;
    i_dmem_rdata = rdata;
    #1;
    chk1({nm, "_stall_ack"}, o_stall, 1'b0);
    tick();
    i_dmem_ack   = 1'b0;
    i_dmem_rdata = 32'd0;
    chk1({nm, "_req_drop"}, o_dmem_req, 1'b0);
    chk1({nm, "_wren"},     o_wr_en, x_wr_en);
    if (x_wr_en) begin
      chk32({nm, "_wrdat"}, o_wr_data, x_wr_data);
      chk32({nm, "_wridx"}, {27'd0, o_wr_idx}, {27'd0, idx});
    end
    chk32({nm, "_stall_cycles"}, stalls, waits + 1);
  endtask

  initial begin
    vecs[0] = '{"alu_op",    32'h0000_1234, 32'h0,  3'b000, 1'b0, 5'd5, 2'b00, 1'b1, 1'b1, 32'h0000_1234, 1'b0};
    vecs[1] = '{"sel11_alu", 32'hDEAD_BEEF, 32'h8,  3'b000, 1'b0, 5'd7, 2'b11, 1'b1, 1'b1, 32'hDEAD_BEEF, 1'b0};
    vecs[2] = '{"jal_x0",    32'h0000_0999, 32'h44, 3'b000, 1'b0, 5'd0, 2'b10, 1'b1, 1'b0, 32'h0,         1'b0};
    vecs[3] = '{"jal_x1",    32'h0000_0999, 32'h44, 3'b000, 1'b0, 5'd1, 2'b10, 1'b1, 1'b1, 32'h0000_0044, 1'b0};
    vecs[4] = '{"bubble",    32'h0,         32'h0,  3'b000, 1'b0, 5'd0, 2'b00, 1'b0, 1'b0, 32'h0,         1'b0};
    vecs[5] = '{"wben0",     32'h0000_0055, 32'h0,  3'b000, 1'b0, 5'd3, 2'b00, 1'b0, 1'b0, 32'h0,         1'b0};
    vecs[6] = '{"lw_mis",    32'h0000_0101, 32'h0,  3'b010, 1'b0, 5'd4, 2'b01, 1'b1, 1'b0, 32'h0,         1'b1};
    vecs[7] = '{"sh_mis",    32'h0000_0201, 32'h0,  3'b001, 1'b1, 5'd0, 2'b00, 1'b0, 1'b0, 32'h0,         1'b1};
    vecs[8] = '{"sw_mis",    32'h0000_0302, 32'h0,  3'b010, 1'b1, 5'd0, 2'b00, 1'b0, 1'b0, 32'h0,         1'b1};
    vecs[9] = '{"lh_mis",    32'h0000_0103, 32'h0,  3'b001, 1'b0, 5'd6, 2'b01, 1'b1, 1'b0, 32'h0,         1'b1};

    rst          = 1'b1;
    i_dmem_ack   = 1'b0;
    i_dmem_rdata = 32'd0;
    bubble();
    #2 rst = 1'b0;
    #1;
    chk_all_zero("reset");
    chk1("reset_stall", o_stall, 1'b0);
    tick();
    tick();
    chk_all_zero("reset_held");
    @(negedge clk);
    rst = 1'b1;
    tick();

    // Single-cycle ops: non-memory writebacks and misaligned accesses.
    for (int v = 0; v < 10; v++) begin
      drive(vecs[v].alu, 32'h0, vecs[v].pc4, vecs[v].f3, vecs[v].mw,
            vecs[v].idx, vecs[v].sel, vecs[v].en);
      #1;
      chk1({vecs[v].name, "_stall"}, o_stall, 1'b0);
      tick();
      chk1({vecs[v].name, "_wren"}, o_wr_en, vecs[v].x_wr_en);
      chk1({vecs[v].name, "_mis"},  o_misalign, vecs[v].x_mis);
      chk1({vecs[v].name, "_req"},  o_dmem_req, 1'b0);
      if (vecs[v].x_wr_en) begin
        chk32({vecs[v].name, "_wrdat"}, o_wr_data, vecs[v].x_wr_data);
        chk32({vecs[v].name, "_wridx"}, {27'd0, o_wr_idx}, {27'd0, vecs[v].idx});
      end
    end
    bubble();
    tick();
    chk1("mis_pulse_end", o_misalign, 1'b0);

    // Ack while idle must not produce anything.
    i_dmem_ack   = 1'b1;
    i_dmem_rdata = 32'hFFFF_FFFF;
    tick();
    i_dmem_ack   = 1'b0;
    chk1("idle_ack_wren", o_wr_en, 1'b0);
    chk1("idle_ack_req",  o_dmem_req, 1'b0);

    // Back-to-back loads and stores.
    do_mem("lb",  32'h103, 32'h0, 3'b000, 1'b0, 5'd9,  2'b01, 1'b1, 2, 32'h80FF_FF00,
           32'h100, 1'b0, 4'b1111, 32'h0, 1'b1, 32'hFFFF_FF80);
    do_mem("lbu", 32'h103, 32'h0, 3'b100, 1'b0, 5'd10, 2'b01, 1'b1, 0, 32'h80FF_FF00,
           32'h100, 1'b0, 4'b1111, 32'h0, 1'b1, 32'h0000_0080);
    do_mem("sh",  32'h202, 32'h0000_ABCD, 3'b001, 1'b1, 5'd0, 2'b00, 1'b0, 1, 32'h0,
           32'h200, 1'b1, 4'b1100, 32'hABCD_ABCD, 1'b0, 32'h0);
    do_mem("lh",  32'h102, 32'h0, 3'b001, 1'b0, 5'd11, 2'b01, 1'b1, 0, 32'h8001_1234,
           32'h100, 1'b0, 4'b1111, 32'h0, 1'b1, 32'hFFFF_8001);
    do_mem("lhu", 32'h102, 32'h0, 3'b101, 1'b0, 5'd12, 2'b01, 1'b1, 1, 32'h8001_1234,
           32'h100, 1'b0, 4'b1111, 32'h0, 1'b1, 32'h0000_8001);
    do_mem("sb",  32'h101, 32'h1234_56A5, 3'b000, 1'b1, 5'd0, 2'b00, 1'b0, 0, 32'h0,
           32'h100, 1'b1, 4'b0010, 32'hA5A5_A5A5, 1'b0, 32'h0);
    do_mem("sw",  32'h300, 32'h1122_3344, 3'b010, 1'b1, 5'd0, 2'b00, 1'b0, 0, 32'h0,
           32'h300, 1'b1, 4'b1111, 32'h1122_3344, 1'b0, 32'h0);
    do_mem("lw",  32'h104, 32'h0, 3'b010, 1'b0, 5'd13, 2'b01, 1'b1, 0, 32'hCAFE_F00D,
           32'h104, 1'b0, 4'b1111, 32'h0, 1'b1, 32'hCAFE_F00D);
    do_mem("lb_pos", 32'h100, 32'h0, 3'b000, 1'b0, 5'd14, 2'b01, 1'b1, 0, 32'h0000_007F,
           32'h100, 1'b0, 4'b1111, 32'h0, 1'b1, 32'h0000_007F);
    do_mem("lw_x0",  32'h108, 32'h0, 3'b010, 1'b0, 5'd0, 2'b01, 1'b1, 0, 32'h5555_5555,
           32'h108, 1'b0, 4'b1111, 32'h0, 1'b0, 32'h0);
    bubble();
    tick();
    chk1("after_mem_wren", o_wr_en, 1'b0);

    // Reset while a request is outstanding, then a late ack.
    drive(32'h400, 32'h0, 32'h404, 3'b010, 1'b0, 5'd15, 2'b01, 1'b1);
    tick();
    chk1("rstwait_req", o_dmem_req, 1'b1);
    #2 rst = 1'b0;
    #1;
    chk_all_zero("rstwait");
    bubble();
    @(negedge clk);
    rst = 1'b1;
    tick();
    i_dmem_ack   = 1'b1;
    i_dmem_rdata = 32'h1234_5678;
    #1;
    chk1("late_ack_stall", o_stall, 1'b0);
    tick();
    i_dmem_ack = 1'b0;
    chk1 ("late_ack_wren",  o_wr_en, 1'b0);
    chk1 ("late_ack_req",   o_dmem_req, 1'b0);
    chk32("late_ack_wrdat", o_wr_data, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
